mvm_32_1_8: RTL and testbench

Signed matrix-vector multiplier: y = A·x for a 32×32 matrix A and a 32-element vector x, with 8-bit signed elements and 16-bit results. It sits behind a byte-serial load interface with one word per cycle and one shared MAC. Results stream out serially after a done pulse. Matrix and vector are stored independently, so either can be reloaded alone between runs.

---
 rtl/mvm_pkg.sv | 18 +
 rtl/mvm_mac.sv | 24 ++
 rtl/mvm_32_1_8.sv | 105 ++++++++++
 tb/tb_mvm_32_1_8.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mvm_pkg.sv
// Shared sizing and FSM encoding for the 32x32 signed matrix-vector multiplier.
package mvm_pkg;
  localparam int K         = 32;
  localparam int B         = 8;
  localparam int OUT_W     = 2 * B;
  localparam int MAT_WORDS = K * K;
  localparam int MIDX_W    = $clog2(MAT_WORDS);
  localparam int VIDX_W    = $clog2(K);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_M  = 3'd1,
    S_LOAD_V  = 3'd2,
    S_COMPUTE = 3'd3,
    S_DONE    = 3'd4,
    S_OUTPUT  = 3'd5
  } state_t;
endpackage

// File: rtl/mvm_mac.sv
// Signed BxB multiply-accumulate; o_sum is the next accumulator value (mod 2^OUT_W).
module mvm_mac
  import mvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_en,
  input  logic                    i_clr,
  input  logic signed [B-1:0]     i_a,
  input  logic signed [B-1:0]     i_b,
  output logic signed [OUT_W-1:0] o_sum
);
  logic signed [OUT_W-1:0] r_acc;
  logic signed [OUT_W-1:0] w_prod;

  assign w_prod = OUT_W'(i_a) * OUT_W'(i_b);
  // i_clr starts a fresh row: the first product replaces the stale accumulator
  assign o_sum  = (i_clr ? '0 : r_acc) + w_prod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_acc <= '0;
    else if (i_en) r_acc <= o_sum;
  end
endmodule

// File: rtl/mvm_32_1_8.sv
// Byte-serial loaded y = A*x engine with one shared MAC and serial result readout.
module mvm_32_1_8
  import mvm_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    loadMatrix,
  input  logic                    loadVector,
  input  logic                    start,
  input  logic signed [B-1:0]     data_in,
  output logic                    done,
  output logic signed [OUT_W-1:0] data_out
);
  localparam logic [MIDX_W-1:0] MAT_LAST = MIDX_W'(MAT_WORDS - 1);
  localparam logic [MIDX_W-1:0] VEC_LAST = MIDX_W'(K - 1);
  localparam logic [VIDX_W-1:0] COL_LAST = VIDX_W'(K - 1);
  localparam logic [VIDX_W:0]   OUT_END  = (VIDX_W + 1)'(K);

  state_t                  r_state;
  logic [MIDX_W-1:0]       r_idx;   // shared by matrix load, vector load and compute
  logic [VIDX_W:0]         r_oidx;
  logic                    r_done;
  logic signed [OUT_W-1:0] r_dout;

  logic signed [B-1:0]     r_mat [MAT_WORDS];
  logic signed [B-1:0]     r_vec [K];
  logic signed [OUT_W-1:0] r_res [K];

  logic [VIDX_W-1:0]       w_col;
  logic [VIDX_W-1:0]       w_row;
  logic                    w_mac_en;
  logic signed [OUT_W-1:0] w_sum;

  assign w_col    = r_idx[VIDX_W-1:0];
  assign w_row    = r_idx[MIDX_W-1:VIDX_W];
  assign w_mac_en = (r_state == S_COMPUTE);

  mvm_mac u_mac (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_mac_en),
    .i_clr (w_col == '0),
    .i_a   (r_mat[r_idx]),
    .i_b   (r_vec[w_col]),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_oidx  <= '0;
      r_done  <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_done <= 1'b0;
      r_dout <= '0;
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (loadMatrix)      r_state <= S_LOAD_M;
          else if (loadVector) r_state <= S_LOAD_V;
          else if (start)      r_state <= S_COMPUTE;
        end
        S_LOAD_M: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == MAT_LAST) r_state <= S_IDLE;
        end
        S_LOAD_V: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == VEC_LAST) r_state <= S_IDLE;
        end
        S_COMPUTE: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == MAT_LAST) r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_oidx  <= '0;
          r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          // K result cycles, then one cycle with data_out back at 0 while returning to IDLE
          if (r_oidx == OUT_END) begin
            r_state <= S_IDLE;
          end else begin
            r_dout <= r_res[r_oidx[VIDX_W-1:0]];
            r_oidx <= r_oidx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Operand and result storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (r_state == S_LOAD_M) r_mat[r_idx] <= data_in;
    if (r_state == S_LOAD_V) r_vec[w_col] <= data_in;
    if (r_state == S_COMPUTE && w_col == COL_LAST) r_res[w_row] <= w_sum;
  end

  assign done     = r_done;
  assign data_out = r_dout;
endmodule

// File: tb/tb_mvm_32_1_8.sv
// Directed vector table plus reload, overrun and mid-compute reset sequences for mvm_32_1_8.
module tb_mvm_32_1_8;
  localparam int K = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              loadMatrix = 1'b0, loadVector = 1'b0, start = 1'b0;
  logic signed [7:0] data_in = '0;
  logic              done;
  logic signed [15:0] data_out;

  int checks = 0;
  int failures = 0;

  mvm_32_1_8 dut (
    .clk(clk), .reset(reset), .loadMatrix(loadMatrix), .loadVector(loadVector),
    .start(start), .data_in(data_in), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mm;     // matrix pattern
    int vm;     // vector pattern
    bit ld_m;
    bit ld_v;
    int base;   // expected y[i] = base + step*i (mod 2^16)
    int step;
  } vec_t;

  function automatic int mval(input int mode, input int r, input int c);
    case (mode)
      0:       return (r == c) ? 1 : 0;
      1:       return 127;
      2:       return -128;
      3:       return 1;
      default: return ((r * 3 + c * 5) % 11) - 5;
    endcase
  endfunction

  function automatic int vval(input int mode, input int c);
    case (mode)
      0:       return c + 1;
      1:       return 127;
      2:       return -128;
      3:       return 2;
      default: return ((c * 7) % 13) - 6;
    endcase
  endfunction

  function automatic logic [15:0] model_y(input int mm, input int vm, input int r);
    int s = 0;
    for (int c = 0; c < K; c++) s += mval(mm, r, c) * vval(vm, c);
    return 16'(s);
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and end at #1 after a rising edge
  task automatic load_m(input int mode, input int words);
    loadMatrix = 1'b1; @(posedge clk); #1 loadMatrix = 1'b0;
    for (int i = 0; i < words; i++) begin
      data_in = 8'(mval(mode, i / K, i % K)); @(posedge clk); #1;
    end
    data_in = '0;
  endtask

  task automatic load_v(input int mode);
    loadVector = 1'b1; @(posedge clk); #1 loadVector = 1'b0;
    for (int i = 0; i < K; i++) begin
      data_in = 8'(vval(mode, i)); @(posedge clk); #1;
    end
    data_in = '0;
  endtask

  task automatic run_check(input string tag, input bit use_model, input int mm, input int vm,
                           input int base, input int step);
    int n = 0;
    bit got = 0, early_out = 0, extra_done = 0;
    logic [15:0] e;
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    while (n < 1500 && !got) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (done) got = 1;
      else if (data_out !== 16'd0) early_out = 1;
    end
    check({tag, " done_seen"}, 16'(got), 16'd1);
    check({tag, " latency"}, 16'(n), 16'd1025);
    check({tag, " dout_zero_before_done"}, 16'(early_out), 16'd0);
    for (int i = 0; i < K; i++) begin
      @(negedge clk);
      if (done) extra_done = 1;
      e = use_model ? model_y(mm, vm, i) : 16'(base + step * i);
      check($sformatf("%s y[%0d]", tag, i), data_out, e);
    end
    @(negedge clk);
    if (done) extra_done = 1;
    check({tag, " dout_zero_after"}, data_out, 16'd0);
    check({tag, " single_done"}, 16'(extra_done), 16'd0);
    @(posedge clk); #1;
  endtask

  vec_t tbl[5];

  initial begin
    tbl[0] = '{mm:1, vm:1, ld_m:1, ld_v:1, base:-8160, step:0};
    tbl[1] = '{mm:2, vm:2, ld_m:1, ld_v:1, base:0,     step:0};
    tbl[2] = '{mm:0, vm:0, ld_m:1, ld_v:1, base:1,     step:1};
    tbl[3] = '{mm:0, vm:3, ld_m:0, ld_v:1, base:2,     step:0};
    tbl[4] = '{mm:3, vm:3, ld_m:1, ld_v:0, base:64,    step:0};

    #2;
    check("reset done", 16'(done), 16'd0);
    check("reset data_out", data_out, 16'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 5; t++) begin
      if (tbl[t].ld_m) load_m(tbl[t].mm, K * K);
      repeat (t) @(posedge clk);
      #1;
      if (tbl[t].ld_v) load_v(tbl[t].vm);
      run_check($sformatf("vec%0d", t), 1'b0, 0, 0, tbl[t].base, tbl[t].step);
    end

    // One word too many after loadMatrix, then an idle gap before the vector
    load_m(4, K * K + 1);
    repeat (7) @(posedge clk);
    #1;
    load_v(4);
    run_check("overrun", 1'b1, 4, 4, 0, 0);

    // Reset mid-compute, then a fresh load must run cleanly
    load_m(0, K * K);
    load_v(0);
    start = 1'b1; @(posedge clk); #1 start = 1'b0;
    repeat (300) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("midreset done", 16'(done), 16'd0);
    check("midreset data_out", data_out, 16'd0);
    @(negedge clk) reset = 1'b1;
    begin
      bit spur = 0;
      for (int i = 0; i < 1200; i++) begin
        @(negedge clk);
        if (done || data_out !== 16'd0) spur = 1;
      end
      check("no_spurious_done", 16'(spur), 16'd0);
    end
    @(posedge clk); #1;
    load_m(4, K * K);
    load_v(0);
    run_check("post_reset", 1'b1, 4, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
